// File: rtl/latch_tx_pkg.sv
// Shared types and width helpers for the latch transmit serializer.
// Optional parity bit is selected by LATCH_TX_PARITY_EN in the top.
package latch_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } tx_state_e;

    // Phase counter must hold the longest phase length minus one, plus margin.
    function automatic int phase_cnt_w(input int s, input int p, input int h);
        int m;
        m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        return $clog2(m) + 1;
    endfunction

    function automatic int bit_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/latch_tx_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Reloaded with (phase length - 1) on every phase entry.
module latch_tx_phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/latch_tx_serializer.sv
// Serializes a parallel word MSB-first onto d_out with a glitch-free le_out strobe.
// Define LATCH_TX_PARITY_EN to append an even-parity bit after the LSB.
module latch_tx_serializer
    import latch_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             d_out,
    output logic             le_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = phase_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int BW = bit_cnt_w(WIDTH);
`ifdef LATCH_TX_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    tx_state_e        state_q, state_d;
    logic [NBITS-1:0] sh_q, sh_d, sh_load, sh_next;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             d_out_q, d_out_d;
    logic             le_out_q, le_out_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmr_load;
    logic [CW-1:0]    tmr_val;
    logic             tmr_tc;

`ifdef LATCH_TX_PARITY_EN
    assign sh_load = {in_data, ^in_data};
`else
    assign sh_load = in_data;
`endif
    assign sh_next = sh_q << 1;

    latch_tx_phase_timer #(.W(CW)) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Outputs are computed for the next state so every output is a flop.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        d_out_d    = d_out_q;
        le_out_d   = 1'b0;
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        unique case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (in_valid && in_ready_q) begin
                    state_d    = SETUP;
                    sh_d       = sh_load;
                    bit_cnt_d  = BW'(NBITS - 1);
                    d_out_d    = sh_load[NBITS-1];
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = CW'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (tmr_tc) begin
                    state_d  = PULSE;
                    le_out_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(PULSE_CYC - 1);
                end
            end
            PULSE: begin
                le_out_d = 1'b1;
                if (tmr_tc) begin
                    state_d  = HOLD;
                    le_out_d = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (tmr_tc) begin
                    if (bit_cnt_q != '0) begin
                        state_d   = SETUP;
                        bit_cnt_d = bit_cnt_q - BW'(1);
                        sh_d      = sh_next;
                        d_out_d   = sh_next[NBITS-1];
                        tmr_load  = 1'b1;
                        tmr_val   = CW'(SETUP_CYC - 1);
                    end else begin
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            d_out_q    <= 1'b0;
            le_out_q   <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            d_out_q    <= d_out_d;
            le_out_q   <= le_out_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign d_out    = d_out_q;
    assign le_out   = le_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_latch_tx_serializer.sv
// Bench for latch_tx_serializer: behavioural D-latch receiver, timing monitor, word scoreboard.
// Honours LATCH_TX_PARITY_EN the same way as the design.
module tb_latch_tx_serializer;

    localparam int WIDTH = 8;
    localparam int S     = 2;
    localparam int P     = 3;
    localparam int H     = 2;
`ifdef LATCH_TX_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int WORD_CYC = NB * (S + P + H);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready, d_out, le_out, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [NB-1:0] exp_q[$];
    logic          got_bits[$];
    logic          last_par = 1'b0;

    latch_tx_serializer #(
        .WIDTH(WIDTH), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d_out    (d_out),
        .le_out   (le_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // The bit sequence a receiver must latch for a word, MSB first.
    function automatic logic [NB-1:0] expect_bits(input logic [WIDTH-1:0] w);
        logic [NB-1:0] r;
        int ones = 0;
        r = '0;
        for (int i = 0; i < WIDTH; i++) ones += int'(w[i]);
        r = NB'(w);
`ifdef LATCH_TX_PARITY_EN
        r = (r << 1) | NB'(ones % 2);
`endif
        return r;
    endfunction

    // Receiver model and timing monitor, sampled on the falling edge.
    logic prev_le = 1'b0, prev_d = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
    logic lq = 1'b0;
    int   cyc = 0, start_cyc = 0, hi_cnt = 0, since_chg = 1000, since_fall = 1000;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            got_bits.delete();
            prev_le = 1'b0; prev_d = d_out; prev_busy = 1'b0; prev_done = 1'b0;
            since_chg = 1000; since_fall = 1000; hi_cnt = 0;
        end else begin
            since_chg++;
            since_fall++;
            if (d_out !== prev_d) begin
                check("d_change_while_le", {31'd0, prev_le | le_out}, 0);
                check("hold_margin", since_fall - 1 >= H, 1);
                since_chg = 1;
            end
            if (le_out && !prev_le) begin
                check("setup_margin", since_chg - 1 >= S, 1);
                hi_cnt = 1;
            end else if (le_out) begin
                hi_cnt++;
            end
            if (le_out) lq = d_out;
            if (!le_out && prev_le) begin
                check("pulse_width", hi_cnt, P);
                got_bits.push_back(lq);
                since_fall = 1;
            end
            if (busy && !prev_busy) start_cyc = cyc;
            if (prev_done) check("done_one_cycle", {31'd0, done}, 0);
            if (done) begin
                logic [NB-1:0] gw;
                gw = '0;
                foreach (got_bits[i]) gw = (gw << 1) | NB'(got_bits[i]);
                check("word_latency", cyc - start_cyc, WORD_CYC);
                check("bit_count", got_bits.size(), NB);
                last_par = lq;
                if (exp_q.size() == 0) check("unexpected_word", 1, 0);
                else check("latched_word", 32'(gw), 32'(exp_q.pop_front()));
                got_bits.delete();
            end
            prev_le = le_out; prev_d = d_out; prev_busy = busy; prev_done = done;
        end
    end

    task automatic send(input logic [WIDTH-1:0] w, input bit hold);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("accept_timeout", n < 400, 1);
        @(posedge clk); #1;
        exp_q.push_back(expect_bits(w));
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready === 1'b1 && busy === 1'b0) && n < 400) begin @(negedge clk); n++; end
        check("idle_timeout", n < 400, 1);
        @(negedge clk);
    endtask

    initial begin
        int n, p;
        logic pl;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_le_out", {31'd0, le_out}, 0);
        check("rst_d_out", {31'd0, d_out}, 0);
        check("rst_done", {31'd0, done}, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Abort mid-pulse during the third bit
        send(8'hA5, 0);
        p = 0; pl = 1'b0; n = 0;
        while (p < 3 && n < 400) begin
            @(negedge clk); n++;
            if (le_out && !pl) p++;
            pl = le_out;
        end
        check("third_pulse_seen", p, 3);
        #2 rst_n = 1'b0;
        #1;
        check("abort_le_out", {31'd0, le_out}, 0);
        check("abort_d_out", {31'd0, d_out}, 0);
        check("abort_in_ready", {31'd0, in_ready}, 1);
        check("abort_busy", {31'd0, busy}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        send(8'h3C, 0);
        check("first_bit_msb", {31'd0, d_out}, 0);
        wait_idle();

        // Single directed word
        send(8'hA5, 0);
        check("a5_msb", {31'd0, d_out}, 1);
        check("a5_busy", {31'd0, busy}, 1);
        wait_idle();

        // Back-to-back with in_valid held high
        send(8'hFF, 1);
        in_data = 8'h00;
        n = 0;
        while (in_ready !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("b2b_done_with_ready", {31'd0, done}, 1);
        check("b2b_last_bit_high", {31'd0, d_out}, 1);
        check("b2b_busy_gap", {31'd0, busy}, 0);
        @(posedge clk); #1;
        exp_q.push_back(expect_bits(8'h00));
        in_valid = 1'b0;
        check("b2b_d_falls_at_setup", {31'd0, d_out}, 0);
        check("b2b_busy_again", {31'd0, busy}, 1);
        wait_idle();

        // Valid while busy is ignored
        send(8'h5A, 0);
        in_data  = 8'hC3;
        in_valid = 1'b1;
        repeat (20) @(negedge clk);
        check("busy_not_ready", {31'd0, in_ready}, 0);
        in_valid = 1'b0;
        wait_idle();

`ifdef LATCH_TX_PARITY_EN
        send(8'h07, 0);
        wait_idle();
        check("parity_07", {31'd0, last_par}, 1);
        send(8'h03, 0);
        wait_idle();
        check("parity_03", {31'd0, last_par}, 0);
`endif

        // Random words with random gaps
        for (int i = 0; i < 16; i++) begin
            send(WIDTH'($urandom), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
